// File: rtl/wb_host_seq.sv
// Single-outstanding Wishbone classic initiator: valid/ready commands in, one response out.
// Optional bus timeout/abort is enabled by defining WB_HOST_TIMEOUT_EN.
module wb_host_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TXN_CNT_W      = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [31:0]          cmd_adr_i,
  input  logic [31:0]          cmd_dat_i,
  input  logic [3:0]           cmd_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  output logic                 busy_o,
  output logic [TXN_CNT_W-1:0] txn_cnt_o
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  localparam logic [TXN_CNT_W-1:0] TxnOne = {{(TXN_CNT_W-1){1'b0}}, 1'b1};

  state_e                 state_q;
  logic                   cyc_q;
  logic                   we_q;
  logic [31:0]            adr_q;
  logic [31:0]            dat_q;
  logic [3:0]             sel_q;
  logic                   rsp_valid_q;
  logic [31:0]            rsp_dat_q;
  logic                   busy_q;
  logic [TXN_CNT_W-1:0]   txn_q;

`ifdef WB_HOST_TIMEOUT_EN
  localparam logic [15:0] ToLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;
  logic        rsp_err_q;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      busy_q      <= 1'b0;
      txn_q       <= '0;
`ifdef WB_HOST_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            we_q     <= cmd_we_i;
            adr_q    <= cmd_adr_i;
            dat_q    <= cmd_dat_i;
            sel_q    <= cmd_sel_i;
            cyc_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StBus;
`ifdef WB_HOST_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        StBus: begin
          // Ack takes priority over timeout expiry on the same edge.
          if (wbm_ack_i) begin
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= we_q ? 32'h0 : wbm_dat_i;
            txn_q       <= txn_q + TxnOne;
            state_q     <= StResp;
`ifdef WB_HOST_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (to_cnt_q == ToLast) begin
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b1;
            txn_q       <= txn_q + TxnOne;
            state_q     <= StResp;
          end else begin
            to_cnt_q    <= to_cnt_q + 16'd1;
`endif
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign busy_o      = busy_q;
  assign txn_cnt_o   = txn_q;
`ifdef WB_HOST_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: doc/wb_host_seq.md
# wb_host_seq

Single-outstanding Wishbone classic initiator that converts a valid/ready command stream into Wishbone read/write cycles and returns one response per command. It is the initiator end of the Wishbone slave interface used by our user-project blocks (slave decodes `adr[23:16]`). It drives those blocks from on-chip logic or LA-driven test sequencers without going through the management SoC.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: bus cycles allowed per transaction before abort. Legal range 2..65535. Used only with the timeout feature.
- `TXN_CNT_W`, default 16: width of the completed-transaction counter.

Ports:
- `wb_clk_i` in 1: single clock. All logic is rising-edge.
- `wb_rst_ni` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i & cmd_ready_o` are high at a clock edge.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_adr_i` in 32: byte address.
- `cmd_dat_i` in 32: write data.
- `cmd_sel_i` in 4: byte selects.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed.
- `rsp_dat_o` out 32: read data. Zero for writes and on abort.
- `rsp_err_o` out 1: transaction aborted by timeout.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: Wishbone cycle, strobe and write enable.
- `wbm_sel_o` out 4, `wbm_adr_o` out 32, `wbm_dat_o` out 32: Wishbone byte selects, address and write data.
- `wbm_dat_i` in 32: Wishbone read data.
- `wbm_ack_i` in 1: Wishbone acknowledge.
- `busy_o` out 1: high in any state other than IDLE.
- `txn_cnt_o` out TXN_CNT_W: count of completed transactions (normal or aborted). Wraps modulo 2^TXN_CNT_W.

## Operation
- FSM states: IDLE, BUS, RESP. All outputs are registered except `cmd_ready_o`, which is decoded from state.
- **IDLE**
  - `cmd_ready_o`=1.
  - On handshake: latch we/adr/dat/sel, clear the timeout counter, go to BUS.
- **BUS**
  - `wbm_cyc_o`=`wbm_stb_o`=1.
  - `wbm_we_o`/`wbm_adr_o`/`wbm_sel_o`/`wbm_dat_o` hold the latched command and stay constant for the whole cycle.
  - On `wbm_ack_i` sampled high:
    - capture `wbm_dat_i` into `rsp_dat_o` for reads (0 for writes);
    - set `rsp_err_o`=0;
    - increment `txn_cnt_o`;
    - go to RESP.
- **RESP**
  - `rsp_valid_o`=1; data and err are held stable.
  - On `rsp_valid_o & rsp_ready_i`: go to IDLE.
- `wbm_ack_i` is ignored outside BUS.
- There is exactly one outstanding transaction. A new command is not accepted until the response has been consumed.
- Reset values: state IDLE; all `wbm_*` outputs 0; `rsp_valid_o`=0; `rsp_dat_o`=0; `rsp_err_o`=0; `txn_cnt_o`=0; `busy_o`=0; `cmd_ready_o`=1.
- Reset asserted mid-transaction:
  - `wbm_cyc_o`/`wbm_stb_o` drop asynchronously.
  - The in-flight command and any pending response are discarded.

## Timing
- Handshake at edge N: cyc/stb are high from edge N+1.
- Ack sampled at edge M:
  - cyc/stb are low after edge M (no extra stb cycle);
  - `rsp_valid_o` is high after edge M.
- Response handshake at edge K: `cmd_ready_o` is high after edge K.
- Minimum command-to-command spacing is 3 cycles, with the slave acking in the first BUS cycle.
- A slave ack asserted combinationally in the first BUS cycle is legal and is taken.

## Configuration
- Macro `WB_HOST_TIMEOUT_EN`.
- **Defined:**
  - A BUS-cycle counter increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 and ack is low on that edge, the block aborts: cyc/stb drop, `rsp_dat_o`=0, `rsp_err_o`=1, `txn_cnt_o` increments, go to RESP.
  - The BUS phase therefore lasts exactly TIMEOUT_CYCLES cycles before abort.
  - If ack and expiry coincide on the same edge, ack wins (normal completion, err=0).
- **Undefined:**
  - No counter logic.
  - BUS waits indefinitely.
  - `rsp_err_o` is tied 0.

## Test plan
- Write 0xDEADBEEF to 0x3001_0000, sel=0xF, slave acks in the first BUS cycle -> cyc/stb high for exactly 1 cycle with adr/dat/we=1 stable; rsp_valid with err=0, dat=0; txn_cnt=1.
- Read 0x3002_0000, slave returns 0x1234_5678 with ack after 3 wait cycles -> stb high for 4 cycles; rsp_dat=0x1234_5678.
- Hold rsp_ready low for 5 cycles after a read -> rsp_valid/dat stable; cmd_ready=0; no new cyc asserted even with cmd_valid high; the command is accepted the cycle after rsp_ready rises.
- Timeout enabled, TIMEOUT_CYCLES=8, slave never acks -> stb high exactly 8 cycles; rsp_err=1, rsp_dat=0; txn_cnt increments.
- Timeout enabled, TIMEOUT_CYCLES=8, ack in the 8th BUS cycle -> normal completion with err=0 and correct read data.
- Assert wb_rst_ni low in the 2nd BUS cycle -> cyc/stb=0 before the next edge; after release: IDLE, cmd_ready=1, txn_cnt=0.
